// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and defaults for the regfile write arbiter.
// Imported by rf_wb_fifo and regfile_wr_arbiter.
package rf_arb_pkg;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] data;
  } rf_wr_req_t;

  localparam int RF_ARB_STARVE_DEF = 4;
  localparam int RF_ARB_DEPTH_DEF  = 2;
  localparam logic [3:0] RF_ARB_CNT_MAX = 4'hF;

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: in-order LLU result buffer with per-entry valid bits and
// invalidate-by-rd so a younger pipeline write can kill stale results.
module rf_wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = RF_ARB_DEPTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  push,
  input  rf_wr_req_t            push_req,
  input  logic                  pop,
  input  logic                  inv,
  input  logic [4:0]            inv_rd,
  output logic                  empty,
  output logic                  full,
  output logic                  head_valid,
  output rf_wr_req_t            head_req,
  output logic [DEPTH-1:0]      ent_valid,
  output logic [DEPTH-1:0][4:0] ent_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  rf_wr_req_t       mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign head_valid = vld[rd_ptr];
  assign head_req   = mem[rd_ptr];
  assign ent_valid  = vld;

  always_comb begin
    ent_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i] = mem[i].rd_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (inv && vld[i] && (mem[i].rd_addr == inv_rd)) begin
          vld[i] <= 1'b0;
        end
      end
      if (do_pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= nxt(rd_ptr);
      end
      // the pushed slot never aliases the popped one: full blocks push
      if (do_push) begin
        mem[wr_ptr] <= push_req;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= nxt(wr_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares one regfile write port between WB and LLU.
// Define RF_WR_ARB_BYPASS_EN to let idle-cycle LLU results skip the buffer.
module regfile_wr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = RF_ARB_STARVE_DEF,
  parameter int FIFO_DEPTH   = RF_ARB_DEPTH_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_valid,
  input  logic [4:0]  i_pipe_rd_addr,
  input  logic [31:0] i_pipe_rd_data,
  input  logic        i_llu_valid,
  input  logic [4:0]  i_llu_rd_addr,
  input  logic [31:0] i_llu_rd_data,
  output logic        o_llu_ready,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_pipe_stall,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_rs1_pending,
  output logic        o_rs2_pending
);

  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       head_valid;
  rf_wr_req_t                 head_req;
  rf_wr_req_t                 push_req;
  logic [FIFO_DEPTH-1:0]      ent_valid;
  logic [FIFO_DEPTH-1:0][4:0] ent_rd;
  logic                       pipe_req;
  logic                       head_live;
  logic                       starved;
  logic                       grant_head;
  logic                       grant_pipe;
  logic                       llu_acc;
  logic                       bypass;
  logic                       push;
  logic                       pop;
  logic [3:0]                 starve_cnt;

  assign pipe_req    = ~i_reset & i_pipe_valid & (i_pipe_rd_addr != '0);
  assign o_llu_ready = ~i_reset & ~fifo_full;
  assign llu_acc     = i_llu_valid & o_llu_ready & (i_llu_rd_addr != '0);
  assign head_live   = ~i_reset & ~fifo_empty & head_valid;
  assign starved     = head_live & (starve_cnt >= 4'(STARVE_LIMIT));
  assign grant_head  = head_live & (starved | ~pipe_req);
  assign grant_pipe  = pipe_req & ~starved;
  assign o_pipe_stall = pipe_req & starved;

`ifdef RF_WR_ARB_BYPASS_EN
  assign bypass = llu_acc & fifo_empty & ~pipe_req;
`else
  assign bypass = 1'b0;
`endif

  assign push     = llu_acc & ~bypass;
  // a killed head drains in one cycle without using the write port
  assign pop      = grant_head | (~i_reset & ~fifo_empty & ~head_valid);
  assign push_req = '{rd_addr: i_llu_rd_addr, data: i_llu_rd_data};

  rf_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (push),
    .push_req  (push_req),
    .pop       (pop),
    .inv       (grant_pipe),
    .inv_rd    (i_pipe_rd_addr),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .head_valid(head_valid),
    .head_req  (head_req),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  always_comb begin
    o_rd_wren = 1'b0;
    o_rd_addr = '0;
    o_rd_data = '0;
    unique case (1'b1)
      grant_pipe: begin
        o_rd_wren = 1'b1;
        o_rd_addr = i_pipe_rd_addr;
        o_rd_data = i_pipe_rd_data;
      end
      grant_head: begin
        o_rd_wren = 1'b1;
        o_rd_addr = head_req.rd_addr;
        o_rd_data = head_req.data;
      end
      bypass: begin
        o_rd_wren = 1'b1;
        o_rd_addr = i_llu_rd_addr;
        o_rd_data = i_llu_rd_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || pop || !head_live) begin
      starve_cnt <= '0;
    end else if (starve_cnt != RF_ARB_CNT_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    o_rs1_pending = 1'b0;
    o_rs2_pending = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == i_rs1_addr)) o_rs1_pending = 1'b1;
      if (ent_valid[i] && (ent_rd[i] == i_rs2_addr)) o_rs2_pending = 1'b1;
    end
    if (i_reset || (i_rs1_addr == '0)) o_rs1_pending = 1'b0;
    if (i_reset || (i_rs2_addr == '0)) o_rs2_pending = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: per-cycle vector table, directed corner sequences
// and a randomized ordering scoreboard for regfile_wr_arbiter.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_pipe_valid = 1'b0;
  logic [4:0]  i_pipe_rd_addr = '0;
  logic [31:0] i_pipe_rd_data = '0;
  logic        i_llu_valid = 1'b0;
  logic [4:0]  i_llu_rd_addr = '0;
  logic [31:0] i_llu_rd_data = '0;
  logic [4:0]  i_rs1_addr = '0;
  logic [4:0]  i_rs2_addr = '0;
  logic        o_llu_ready;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_pipe_stall;
  logic        o_rs1_pending;
  logic        o_rs2_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_pipe_valid  (i_pipe_valid),
    .i_pipe_rd_addr(i_pipe_rd_addr),
    .i_pipe_rd_data(i_pipe_rd_data),
    .i_llu_valid   (i_llu_valid),
    .i_llu_rd_addr (i_llu_rd_addr),
    .i_llu_rd_data (i_llu_rd_data),
    .o_llu_ready   (o_llu_ready),
    .o_rd_wren     (o_rd_wren),
    .o_rd_addr     (o_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_pipe_stall  (o_pipe_stall),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .o_rs1_pending (o_rs1_pending),
    .o_rs2_pending (o_rs2_pending)
  );

  typedef struct packed {
    logic        rst;
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ewr;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        est;
    logic        erdy;
    logic        ep1;
    logic        ep2;
  } vec_t;

  vec_t        tbl[$];
  logic [36:0] sb_q[$];
  logic [36:0] llu_q[$];

  function automatic vec_t mk(
    input logic rst, input logic pv, input logic [4:0] prd,
    input logic [31:0] pd, input logic lv, input logic [4:0] lrd,
    input logic [31:0] ld, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic ewr, input logic [4:0] ea, input logic [31:0] ed,
    input logic est, input logic erdy, input logic ep1, input logic ep2);
    vec_t v;
    v = '{rst, pv, prd, pd, lv, lrd, ld, rs1, rs2,
          ewr, ea, ed, est, erdy, ep1, ep2};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [36:0] e;
    @(posedge clk);
    #1;
    i_reset        = v.rst;
    i_pipe_valid   = v.pv;
    i_pipe_rd_addr = v.prd;
    i_pipe_rd_data = v.pd;
    i_llu_valid    = v.lv;
    i_llu_rd_addr  = v.lrd;
    i_llu_rd_data  = v.ld;
    i_rs1_addr     = v.rs1;
    i_rs2_addr     = v.rs2;
    @(negedge clk);
    if (v.ewr) sb_q.push_back({v.ea, v.ed});
    chk($sformatf("v%0d wren", idx), 32'(o_rd_wren), 32'(v.ewr));
    chk($sformatf("v%0d stall", idx), 32'(o_pipe_stall), 32'(v.est));
    chk($sformatf("v%0d ready", idx), 32'(o_llu_ready), 32'(v.erdy));
    chk($sformatf("v%0d rs1_pend", idx), 32'(o_rs1_pending), 32'(v.ep1));
    chk($sformatf("v%0d rs2_pend", idx), 32'(o_rs2_pending), 32'(v.ep2));
    if (o_rd_wren) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL v%0d write: got rd=%0d data=%h expected none",
                 idx, o_rd_addr, o_rd_data);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d addr", idx), 32'(o_rd_addr), 32'(e[36:32]));
        chk($sformatf("v%0d data", idx), o_rd_data, e[31:0]);
      end
    end else begin
      chk($sformatf("v%0d idle_addr", idx), 32'(o_rd_addr), 32'd0);
      chk($sformatf("v%0d idle_data", idx), o_rd_data, 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic idle_row(input int idx, input logic [4:0] rs1,
                          input logic ep1);
    apply(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, rs1, 5'd0,
             1'b0, 5'd0, 32'h0, 1'b0, 1'b1, ep1, 1'b0), idx);
  endtask

  initial begin : main
    logic        held;
    logic [36:0] e;
    int          wait_cnt;

    // reset with requests present, then pipe-only writes
    tbl.push_back(mk(1'b1, 1'b1, 5'd5, 32'h1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd5,
                     1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5,
                     1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                     5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1,
                     1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd0, 32'h11, 1'b0, 5'd0, 32'h0,
                     5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    // starvation: rd=3 buffered while pipe writes every cycle
    tbl.push_back(mk(1'b0, 1'b1, 5'd20, 32'hD0, 1'b1, 5'd3, 32'h33,
                     5'd3, 5'd0, 1'b1, 5'd20, 32'hD0, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(mk(1'b0, 1'b1, 5'(21 + k), 32'(32'hD1 + k), 1'b0, 5'd0,
                       32'h0, 5'd3, 5'd0, 1'b1, 5'(21 + k), 32'(32'hD1 + k),
                       1'b0, 1'b1, 1'b1, 1'b0));
    end
    tbl.push_back(mk(1'b0, 1'b1, 5'd25, 32'hD5, 1'b0, 5'd0, 32'h0,
                     5'd3, 5'd0, 1'b1, 5'd3, 32'h33, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd25, 32'hD5, 1'b0, 5'd0, 32'h0,
                     5'd3, 5'd0, 1'b1, 5'd25, 32'hD5, 1'b0, 1'b1, 1'b0, 1'b0));
    // full FIFO and WAW kill of rd=9
    tbl.push_back(mk(1'b0, 1'b1, 5'd20, 32'hA0, 1'b1, 5'd9, 32'h99,
                     5'd9, 5'd10, 1'b1, 5'd20, 32'hA0, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd21, 32'hA1, 1'b1, 5'd10, 32'hAA,
                     5'd9, 5'd10, 1'b1, 5'd21, 32'hA1, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd9, 32'h90, 1'b1, 5'd11, 32'hBB,
                     5'd9, 5'd10, 1'b1, 5'd9, 32'h90, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     5'd9, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     5'd9, 5'd10, 1'b1, 5'd10, 32'hAA, 1'b0, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     5'd9, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    // reset with two buffered results
    tbl.push_back(mk(1'b0, 1'b1, 5'd20, 32'hC0, 1'b1, 5'd13, 32'hD3,
                     5'd13, 5'd14, 1'b1, 5'd20, 32'hC0, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd21, 32'hC1, 1'b1, 5'd14, 32'hD4,
                     5'd13, 5'd14, 1'b1, 5'd21, 32'hC1, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd22, 32'hC2, 1'b0, 5'd0, 32'h0,
                     5'd13, 5'd14, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                       5'd13, 5'd14, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
                       1'b0, 1'b0));
    end
    // simultaneous push and pop keeps order
    tbl.push_back(mk(1'b0, 1'b1, 5'd20, 32'hE0, 1'b1, 5'd15, 32'hE5,
                     5'd15, 5'd17, 1'b1, 5'd20, 32'hE0, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 32'hE7,
                     5'd15, 5'd17, 1'b1, 5'd15, 32'hE5, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     5'd15, 5'd17, 1'b1, 5'd17, 32'hE7, 1'b0, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                     5'd15, 5'd17, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

`ifdef RF_WR_ARB_BYPASS_EN
    apply(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hA5A5A5A5,
             5'd12, 5'd0, 1'b1, 5'd12, 32'hA5A5A5A5, 1'b0, 1'b1,
             1'b0, 1'b0), 100);
    idle_row(101, 5'd12, 1'b0);
    apply(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77,
             5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0), 102);
    idle_row(103, 5'd0, 1'b0);
`else
    apply(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678,
             5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0), 100);
    apply(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             5'd7, 5'd0, 1'b1, 5'd7, 32'h12345678, 1'b0, 1'b1,
             1'b1, 1'b0), 101);
    idle_row(102, 5'd7, 1'b0);
    apply(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77,
             5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0), 103);
    idle_row(104, 5'd0, 1'b0);
`endif

    // random traffic: pipe rd 16..31, LLU rd 0..15, so no WAW kills
    held = 1'b0;
    wait_cnt = 0;
    for (int c = 0; c < 420; c++) begin
      @(posedge clk);
      #1;
      i_rs1_addr = '0;
      i_rs2_addr = '0;
      if (!held) begin
        i_pipe_valid   = (c < 380) && ($urandom_range(0, 2) != 0);
        i_pipe_rd_addr = 5'($urandom_range(16, 31));
        i_pipe_rd_data = $urandom;
      end
      i_llu_valid   = (c < 380) && ($urandom_range(0, 1) != 0);
      i_llu_rd_addr = 5'($urandom_range(0, 15));
      i_llu_rd_data = $urandom;
      @(negedge clk);
      if (i_llu_valid && o_llu_ready && (i_llu_rd_addr != '0)) begin
        llu_q.push_back({i_llu_rd_addr, i_llu_rd_data});
      end
      if (o_rd_wren && (o_rd_addr >= 5'd16)) begin
        chk("rnd pipe_grant", 32'(i_pipe_valid && !o_pipe_stall), 32'd1);
        chk("rnd pipe_addr", 32'(o_rd_addr), 32'(i_pipe_rd_addr));
        chk("rnd pipe_data", o_rd_data, i_pipe_rd_data);
      end else begin
        chk("rnd pipe_not_granted", 32'(i_pipe_valid && !o_pipe_stall),
            32'd0);
      end
      if (o_rd_wren && (o_rd_addr < 5'd16)) begin
        wait_cnt = 0;
        if (llu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd llu_write: got rd=%0d expected none", o_rd_addr);
        end else begin
          e = llu_q.pop_front();
          chk("rnd llu_addr", 32'(o_rd_addr), 32'(e[36:32]));
          chk("rnd llu_data", o_rd_data, e[31:0]);
        end
      end else if (llu_q.size() != 0) begin
        wait_cnt++;
        if (wait_cnt > 5) begin
          checks++;
          errors++;
          $display("FAIL rnd starve: waited %0d cycles, limit 5", wait_cnt);
          wait_cnt = 0;
        end
      end
      held = o_pipe_stall;
    end
    chk("rnd drained", 32'(llu_q.size()), 32'd0);
    chk("rnd ready_end", 32'(o_llu_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive ungranted cycles of a pending FIFO head before the pipeline is stalled (legal range 1..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning long-latency-unit (LLU) result buffer entries (legal range 2..4).
REQ-003 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_pipe_valid in 1, i_pipe_rd_addr in 5, i_pipe_rd_data in 32: the pipeline WB write request, held stable while o_pipe_stall=1.
REQ-006 SHALL have ports i_llu_valid in 1, i_llu_rd_addr in 5, i_llu_rd_data in 32, o_llu_ready out 1: LLU result valid/ready handshake.
REQ-007 SHALL have ports o_rd_wren out 1, o_rd_addr out 5, o_rd_data out 32: the single regfile write port.
REQ-008 SHALL have port o_pipe_stall  out  1  freezes the pipeline when the FIFO head takes the write port.
REQ-009 SHALL have ports i_rs1_addr in 5, i_rs2_addr in 5, o_rs1_pending out 1, o_rs2_pending out 1: ID-stage scoreboard query.

Function
REQ-010 SHALL accept an LLU result on the rising edge where i_llu_valid=1 and o_llu_ready=1; o_llu_ready SHALL be 1 iff the FIFO is not full (registered occupancy; a same-cycle pop SHALL NOT raise ready).
REQ-011 SHALL discard an accepted LLU result with rd=0 (no FIFO push); a pipeline request with rd=0 SHALL count as no request.
REQ-012 SHALL grant the write port, per cycle, in priority: (a) FIFO head if starvation count >= STARVE_LIMIT; (b) pipeline request; (c) FIFO head.
REQ-013 SHALL assert o_pipe_stall combinationally only in case (a) with a pipeline request present; otherwise 0.
REQ-014 SHALL drive o_rd_wren=1 with the granted addr/data in the same cycle (zero added latency for pipeline writes); o_rd_addr/o_rd_data SHALL be 0 when o_rd_wren=0.
REQ-015 SHALL pop the FIFO head on the edge it is granted; pops SHALL preserve FIFO (acceptance) order.
REQ-016 SHALL keep a starvation counter: increment (saturating at 15) each cycle the head is valid and not popped; clear on any pop or when empty.
REQ-017 SHALL, when a pipeline write to rd is granted, invalidate every FIFO entry with the same rd (later program-order write wins); an invalidated head SHALL be popped in one cycle without asserting o_rd_wren and SHALL clear the counter.
REQ-018 SHALL drive o_rsN_pending=1 iff i_rsN_addr!=0 and matches rd of any valid FIFO entry (registered contents; same-cycle push not included).
REQ-019 SHALL handle simultaneous push and pop: occupancy unchanged, the pushed entry goes to tail.
REQ-020 SHALL wrap read/write pointers modulo FIFO_DEPTH.

Reset
REQ-021 SHALL, while i_reset=1, drive o_rd_wren=0, o_pipe_stall=0, o_llu_ready=0, o_rsN_pending=0, and ignore all requests.
REQ-022 SHALL, on the edge i_reset is sampled 1, empty the FIFO, clear all entry valids, pointers and the starvation counter; reset mid-operation SHALL drop buffered results without writing them; o_llu_ready=1 in the first cycle after reset.

Configuration
REQ-023 SHALL, with macro RF_WR_ARB_BYPASS_EN defined, write an LLU result straight to the regfile in its acceptance cycle when the FIFO is empty, no pipeline request is present and rd!=0 (no push).
REQ-024 SHALL, without RF_WR_ARB_BYPASS_EN, always route LLU results through the FIFO (minimum 1-cycle acceptance-to-write latency).

Structure
REQ-025 SHALL take from shared package rf_arb_pkg: typedef rf_wr_req_t {rd_addr[4:0], data[31:0]}, constants RF_ARB_STARVE_DEF=4, RF_ARB_DEPTH_DEF=2.
REQ-026 SHALL implement the buffer as sub-module rf_wb_fifo (entries with valid bit, per-entry invalidate-by-rd, head/tail pointers, occupancy); arbitration, counter and scoreboard stay in the top.

Verification
REQ-027 Pipe-only: i_pipe_valid=1, rd=5, data=0xDEADBEEF -> o_rd_wren=1, rd=5, data=0xDEADBEEF same cycle, stall=0.
REQ-028 LLU in idle (no macro): LLU rd=7, data=0x12345678 accepted cycle N -> write rd=7 at cycle N+1; o_rs1_pending=1 for rs1=7 during N+1 only.
REQ-029 Starvation: FIFO holds rd=3, pipe writes every cycle -> pipe granted 4 cycles, 5th cycle stall=1 and rd=3 written, pipe write of the held request next cycle.
REQ-030 Full/WAW: fill 2 entries rd=9, rd=10 -> o_llu_ready=0; pipe write rd=9 -> rd=9 entry dropped (never written), rd=10 written later, ready returns 1 after pop.
REQ-031 Reset mid-operation: FIFO holds 2 entries, i_reset=1 one cycle -> no further o_rd_wren for those entries, pending=0, ready=1 next cycle.
REQ-032 Bypass (macro defined): empty FIFO, no pipe request, LLU rd=12, data=0xA5A5A5A5 -> written same cycle; LLU rd=0 -> no write, no push.
